// File: rtl/nonce_scheduler.sv
// Advent-coin search sequencer: issues ASCII decimal nonces to the MD5 pipeline
// under a credit limit, retires digests in order and reports the first hit.

module nonce_digit (
    input  logic [7:0] cur,
    input  logic       cin,
    output logic [7:0] nxt,
    output logic       cout
);
    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        if (cin) begin
            if (cur == 8'h00) begin
                nxt = 8'h31;  // carry into an empty byte lengthens the number
            end else if (cur == 8'h39) begin
                nxt  = 8'h30;
                cout = 1'b1;
            end else begin
                nxt = cur + 8'd1;
            end
        end
    end
endmodule

module nonce_scheduler #(
    parameter int BLOCK_HEADER_WIDTH = 64,
    parameter int RESULT_WIDTH       = 32,
    parameter int DIGEST_WIDTH       = 128,
    parameter int ZERO_NIBBLES       = 5,
    parameter int MAX_INFLIGHT       = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          hdr_valid,
    input  logic                          hdr_ready,
    output logic [BLOCK_HEADER_WIDTH-1:0] hdr_data,
    input  logic                          digest_valid,
    input  logic [DIGEST_WIDTH-1:0]       digest_data,
    output logic                          result_valid,
    output logic [RESULT_WIDTH-1:0]       result_data,
    output logic                          result_error
);
    localparam int DIGITS = BLOCK_HEADER_WIDTH / 8;
    localparam int IW     = $clog2(MAX_INFLIGHT + 1);
    localparam int ZW     = 4 * ZERO_NIBBLES;
    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);
    localparam logic [DIGITS-1:0][7:0] CTR_ONE = BLOCK_HEADER_WIDTH'(8'h31);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [DIGITS-1:0][7:0]  ctr, ctr_nxt;
    logic [DIGITS:0]         carry;
    logic [IW-1:0]           inflight, inflight_nxt;
    logic [RESULT_WIDTH-1:0] retire_nonce, win_nonce;
    logic                    exhausted, exhausted_nxt, hit, xfer, hit_now;
    logic                    unused_digest_bits;

    assign carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            nonce_digit u_digit (
                .cur  (ctr[g]),
                .cin  (carry[g]),
                .nxt  (ctr_nxt[g]),
                .cout (carry[g+1])
            );
        end
    endgenerate

    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign hdr_valid     = (state == S_RUN) && !exhausted && (inflight < MAX_CNT);
    assign hdr_data      = ctr;
    assign xfer          = hdr_valid && hdr_ready;
    assign hit_now       = digest_valid && (digest_data[DIGEST_WIDTH-1 -: ZW] == '0);
    assign exhausted_nxt = exhausted || (xfer && carry[DIGITS]);
    assign result_valid  = (state == S_DONE);
    assign result_error  = (state == S_DONE) && !hit;
    assign result_data   = win_nonce;
    assign unused_digest_bits = ^digest_data[DIGEST_WIDTH-ZW-1:0];

    always_comb begin
        inflight_nxt = inflight;
        if (xfer && !digest_valid)      inflight_nxt = inflight + IW'(1);
        else if (!xfer && digest_valid) inflight_nxt = inflight - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ctr          <= '0;
            inflight     <= '0;
            retire_nonce <= '0;
            win_nonce    <= '0;
            exhausted    <= 1'b0;
            hit          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ctr          <= CTR_ONE;
                    retire_nonce <= RESULT_WIDTH'(1);
                    win_nonce    <= '0;
                    inflight     <= '0;
                    exhausted    <= 1'b0;
                    hit          <= 1'b0;
                    state        <= S_RUN;
                end
                S_RUN: begin
                    inflight  <= inflight_nxt;
                    exhausted <= exhausted_nxt;
                    if (xfer) ctr <= ctr_nxt;
                    if (hit_now) begin
                        win_nonce <= retire_nonce;
                        hit       <= 1'b1;
                        state     <= S_DRAIN;
                    end else begin
                        if (digest_valid) retire_nonce <= retire_nonce + RESULT_WIDTH'(1);
                        if (exhausted_nxt && inflight_nxt == '0) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // late digests only return credit; further hits are discarded
                    inflight <= inflight_nxt;
                    if (inflight_nxt == '0) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    no_orphan_digest: assert property (@(posedge clk) disable iff (reset)
        digest_valid |-> (inflight != '0));

endmodule

// File: tb/tb_nonce_scheduler.sv
// Randomised scoreboard bench for nonce_scheduler: pipeline model, in-order
// digest return, expected results queued at start and checked by a monitor.

module tb_nonce_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b;
    logic busy_a, hv_a, hr_a, dv_a, rv_a, re_a;
    logic [63:0]  hd_a;
    logic [127:0] dd_a;
    logic [31:0]  rd_a;
    logic busy_b, hv_b, hr_b, dv_b, rv_b, re_b;
    logic [15:0]  hd_b;
    logic [127:0] dd_b;
    logic [31:0]  rd_b;

    nonce_scheduler #(.BLOCK_HEADER_WIDTH(64), .MAX_INFLIGHT(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
        .hdr_valid(hv_a), .hdr_ready(hr_a), .hdr_data(hd_a),
        .digest_valid(dv_a), .digest_data(dd_a),
        .result_valid(rv_a), .result_data(rd_a), .result_error(re_a));

    nonce_scheduler #(.BLOCK_HEADER_WIDTH(16), .MAX_INFLIGHT(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
        .hdr_valid(hv_b), .hdr_ready(hr_b), .hdr_data(hd_b),
        .digest_valid(dv_b), .digest_data(dd_b),
        .result_valid(rv_b), .result_data(rd_b), .result_error(re_b));

    typedef struct packed { logic err; logic [31:0] data; } res_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, cyc_b = 0;
    bit hit_tab [256];
    bit ret_en, rel_one, rdy_rand, lat_rand;
    int lat;
    int pq_n[$], pq_t[$], qb[$];
    int exp_n, nxfer, expb, nxb;
    int res_cnt_a = 0, res_cnt_b = 0;
    bit hit_seen, drain_chk, done_chk, stall_prev;
    logic [63:0] held;
    logic [15:0] last_hd_b;
    res_t exp_res_a[$], exp_res_b[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] to_ascii(input int unsigned n);
        logic [63:0] r;
        int unsigned v;
        r = '0;
        v = n;
        for (int i = 0; i < 8; i++) begin
            if (v != 0) begin
                r[i*8 +: 8] = 8'h30 + 8'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // Misses set one bit inside the leading 20 bits; hits leave them all zero.
    function automatic logic [127:0] mk_digest(input bit h);
        logic [127:0] d;
        int k;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[127:108] = '0;
        if (!h) begin
            k = 108 + int'($urandom_range(0, 19));
            d[k] = 1'b1;
        end
        return d;
    endfunction

    // Pipeline model and header checker for instance A.
    initial begin
        int n, ret;
        bit h;
        hr_a = 1'b0; dv_a = 1'b0; dd_a = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (drain_chk) begin chk("hit_stops_issue", 128'({busy_a, hv_a}), 128'(2'b10)); drain_chk = 0; end
            if (done_chk)  begin chk("done_after_drain", 128'(rv_a), 128'(1'b1)); done_chk = 0; end
            if (stall_prev && hv_a) chk("hdr_stable", 128'(hd_a), 128'(held));
            stall_prev = 0;
            if (reset) begin
                pq_n.delete(); pq_t.delete(); hr_a = 1'b0; dv_a = 1'b0;
                continue;
            end
            if (start_a && !busy_a) begin exp_n = 1; nxfer = 0; hit_seen = 0; end
            hr_a = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            dv_a = 1'b0;
            if (pq_n.size() > 0 && (ret_en || rel_one) && pq_t[0] <= cyc) begin
                n = pq_n.pop_front();
                void'(pq_t.pop_front());
                h = (n < 256) && hit_tab[n];
                dv_a = 1'b1;
                dd_a = mk_digest(h);
                rel_one = 0;
                if (h && !hit_seen) begin hit_seen = 1; drain_chk = 1; end
                else if (hit_seen && pq_n.size() == 0) done_chk = 1;
            end
            if (hv_a && hr_a) begin
                chk("hdr_data", 128'(hd_a), 128'(to_ascii(exp_n)));
                case (exp_n)
                    9:   chk("hdr_9",   128'(hd_a), 128'(64'h39));
                    10:  chk("hdr_10",  128'(hd_a), 128'(64'h3130));
                    99:  chk("hdr_99",  128'(hd_a), 128'(64'h3939));
                    100: chk("hdr_100", 128'(hd_a), 128'(64'h313030));
                    default: ;
                endcase
                ret = cyc + (lat_rand ? int'($urandom_range(1, 12)) : lat);
                pq_n.push_back(exp_n);
                pq_t.push_back(ret);
                exp_n++;
                nxfer++;
            end
            if (hv_a && !hr_a) begin stall_prev = 1; held = hd_a; end
        end
    end

    // Pipeline model for the two-digit instance: fixed latency, never hits.
    initial begin
        hr_b = 1'b1; dv_b = 1'b0; dd_b = '0;
        forever begin
            @(negedge clk);
            cyc_b++;
            if (reset) begin qb.delete(); dv_b = 1'b0; continue; end
            if (start_b && !busy_b) begin expb = 1; nxb = 0; end
            dv_b = 1'b0;
            if (qb.size() > 0 && qb[0] <= cyc_b) begin
                void'(qb.pop_front());
                dv_b = 1'b1;
                dd_b = mk_digest(1'b0);
            end
            if (hv_b) begin
                chk("hdr_b", 128'(hd_b), 128'(16'(to_ascii(expb))));
                last_hd_b = hd_b;
                qb.push_back(cyc_b + 3);
                expb++;
                nxb++;
            end
        end
    end

    // Result monitor.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rv_a) begin
                if (exp_res_a.size() == 0) chk("result_a_unexpected", 128'(rv_a), 128'(1'b0));
                else begin
                    r = exp_res_a.pop_front();
                    chk("result_err_a",  128'(re_a), 128'(r.err));
                    chk("result_data_a", 128'(rd_a), 128'(r.data));
                    chk("retired_all_a", 128'(pq_n.size()), 128'(0));
                end
                res_cnt_a++;
            end
            if (rv_b) begin
                if (exp_res_b.size() == 0) chk("result_b_unexpected", 128'(rv_b), 128'(1'b0));
                else begin
                    r = exp_res_b.pop_front();
                    chk("result_err_b",  128'(re_b), 128'(r.err));
                    chk("result_data_b", 128'(rd_b), 128'(r.data));
                    chk("issued_b",      128'(nxb), 128'(99));
                    chk("last_hdr_b",    128'(last_hd_b), 128'(16'h3939));
                    chk("retired_all_b", 128'(qb.size()), 128'(0));
                end
                res_cnt_b++;
            end
        end
    end

    task automatic clr_hits();
        foreach (hit_tab[i]) hit_tab[i] = 1'b0;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("start_busy", 128'({busy_a, hv_a}), 128'(2'b11));
    endtask

    task automatic wait_res_a(input int budget);
        int tgt;
        tgt = res_cnt_a + 1;
        for (int i = 0; i < budget && res_cnt_a < tgt; i++) @(posedge clk);
        #1;
        chk("result_a_seen", 128'(res_cnt_a >= tgt), 128'(1'b1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_a"}, 128'({busy_a, hv_a, hd_a, rv_a, rd_a, re_a}), 128'(0));
        chk({nm, "_b"}, 128'({busy_b, hv_b, hd_b, rv_b, rd_b, re_b}), 128'(0));
    endtask

    initial begin
        int tgt;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        rdy_rand = 0; lat_rand = 0; ret_en = 1; rel_one = 0; lat = 10;
        clr_hits();
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;

        // basic hit at nonce 3
        hit_tab[3] = 1;
        exp_res_a.push_back('{1'b0, 32'd3});
        pulse_a();
        wait_res_a(300);
        clr_hits();

        // credit limit: nothing returns until released
        ret_en = 0;
        hit_tab[3] = 1;
        exp_res_a.push_back('{1'b0, 32'd3});
        pulse_a();
        repeat (30) @(posedge clk); #1;
        chk("credit_xfers", 128'(nxfer), 128'(4));
        chk("credit_hold",  128'(hv_a), 128'(1'b0));
        rel_one = 1;
        repeat (20) @(posedge clk); #1;
        chk("credit_one_more", 128'(nxfer), 128'(5));
        chk("credit_hold2",    128'(hv_a), 128'(1'b0));
        ret_en = 1;
        wait_res_a(300);
        clr_hits();

        // backpressure, second hit during drain, ignored start while busy
        rdy_rand = 1;
        hit_tab[17] = 1; hit_tab[18] = 1;
        exp_res_a.push_back('{1'b0, 32'd17});
        pulse_a();
        repeat (8) @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_res_a(1000);
        rdy_rand = 0;
        clr_hits();

        // long run through the 9->10 and 99->100 carries, random latency
        lat_rand = 1;
        hit_tab[120] = 1;
        exp_res_a.push_back('{1'b0, 32'd120});
        pulse_a();
        wait_res_a(3000);
        lat_rand = 0;
        clr_hits();

        // reset mid-search, then a fresh search restarts at "1"
        pulse_a();
        tgt = 0;
        while (exp_n <= 50 && tgt < 2000) begin @(posedge clk); tgt++; end
        #1;
        chk("reached_50", 128'(exp_n > 50), 128'(1'b1));
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle_zero("mid_reset");
        reset = 1'b0;
        hit_tab[2] = 1;
        exp_res_a.push_back('{1'b0, 32'd2});
        pulse_a();
        wait_res_a(300);
        clr_hits();

        // two-digit instance runs out of nonces
        exp_res_b.push_back('{1'b1, 32'd0});
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("start_busy_b", 128'({busy_b, hv_b}), 128'(2'b11));
        tgt = res_cnt_b + 1;
        for (int i = 0; i < 2000 && res_cnt_b < tgt; i++) @(posedge clk);
        #1;
        chk("result_b_seen", 128'(res_cnt_b >= tgt), 128'(1'b1));
        repeat (3) @(posedge clk); #1;
        chk("pending_results", 128'(exp_res_a.size() + exp_res_b.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
